instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Read-side sequencer for the instruction buffer. On a start pulse it reads a contiguous run of instruction words from the buffer, starting at a programmed base address. It drives the buffer's read enable and read address, captures each returned word and presents it to the IMC core over a valid/ready handshake. It then reports completion with a done pulse.

## Interface
- DATA_WIDTH, 32: instruction word width; equals the buffer data width.
- ADDR_WIDTH, 4: buffer address width; the buffer holds 2^ADDR_WIDTH words.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first buffer address; sampled with start.
- instr_count  in  ADDR_WIDTH+1  number of words to fetch (0..2^ADDR_WIDTH); sampled with start.
- buf_empty  in  1  buffer empty flag.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  ADDR_WIDTH  buffer read address.
- buf_data  in  DATA_WIDTH  buffer registered read data; valid the cycle after buf_rd_en.
- instr_valid  out  1  instr_data holds an unconsumed word.
- instr_ready  in  1  consumer accepts the word.
- instr_data  out  DATA_WIDTH  current instruction word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- States:
  - IDLE
  - FETCH: issue read.
  - CAPTURE: load buf_data.
  - PRESENT: hold word for handshake.
  - DONE: pulse done.
- IDLE, start=1:
  - latch base_addr into rd_ptr and instr_count into remaining.
  - go to DONE if instr_count==0, else to FETCH.
- start while not IDLE: ignored; base_addr and instr_count are not re-sampled.
- FETCH:
  - buf_rd_en = !buf_empty (decoded from state).
  - buf_rd_addr = rd_ptr (registered).
  - if buf_empty: stay in FETCH with no read; this stall may last indefinitely.
  - else: go to CAPTURE; rd_ptr increments and remaining decrements.
- rd_ptr is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH (e.g. base 14, count 4 reads 14, 15, 0, 1).
- CAPTURE: instr_data <= buf_data, instr_valid <= 1, go to PRESENT.
- PRESENT:
  - instr_data and instr_valid hold until instr_valid && instr_ready at a clock edge.
  - at that edge instr_valid <= 0, then go to DONE if remaining==0, else to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- instr_data retains its last value after a handshake and after the run ends.
- buf_rd_en is never asserted outside FETCH and never while buf_empty=1.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; rd_ptr=0; remaining=0.
  - buf_rd_en=0, buf_rd_addr=0, instr_valid=0, instr_data=0, busy=0, done=0.
  - reset mid-run abandons the run with no done pulse.
- Start at cycle 0 with the buffer non-empty:
  - cycle 1: FETCH, buf_rd_en=1.
  - cycle 2: CAPTURE.
  - cycle 3: instr_valid=1.
- With instr_ready tied high, each word costs 3 cycles (FETCH, CAPTURE, PRESENT). For N words: last handshake at cycle 3N, done at cycle 3N+1, IDLE at cycle 3N+2.
- instr_count=0: done in cycle 1, IDLE in cycle 2, no buffer read.
- A new start is accepted in the first IDLE cycle after DONE.
- instr_valid must not drop before the handshake, and instr_data must not change while instr_valid=1.

## Structure
- Shared package, ifc_pkg: FSM state encoding localparams (IDLE=0, FETCH=1, CAPTURE=2, PRESENT=3, DONE=4; 3 bits) and the default DATA_WIDTH/ADDR_WIDTH constants, shared with the buffer instance.
- Single module, no sub-module; the address counter and remaining counter are inline registers.

## Test plan
- Basic run: buffer preloaded with 0xA0..0xA3 at addresses 0..3; base=0, count=4, instr_ready=1 -> instr_data sequence 0xA0, 0xA1, 0xA2, 0xA3, each valid at cycles 3, 6, 9, 12; done at cycle 13.
- Wrap: base=14, count=4 -> buf_rd_addr sequence 14, 15, 0, 1; 4 handshakes; single done pulse.
- Backpressure: instr_ready low for 5 cycles after the first instr_valid -> instr_valid and instr_data stable for those cycles; no buf_rd_en until the handshake; total run 5 cycles longer.
- Empty stall: buf_empty=1 for 4 cycles during FETCH -> buf_rd_en=0 throughout, busy=1; read issued in the cycle buf_empty falls.
- Zero count, and start while busy: count=0 -> done at cycle 1 with no buf_rd_en. A second start during a run is ignored -> run completes with the original count and address.
- Reset mid-run: rst_n=0 in PRESENT -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start then fetches from the new base.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants for the instruction-buffer read side: FSM state encoding
// and the default buffer geometry, also used by the buffer instance.
package ifc_pkg;

    localparam int IFC_DATA_WIDTH = 32;
    localparam int IFC_ADDR_WIDTH = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Buffer read port plus the valid/ready instruction stream towards the IMC core.
// The master side is the fetch controller.
interface instr_fetch_ctrl_if #(
    parameter int DATA_WIDTH = ifc_pkg::IFC_DATA_WIDTH,
    parameter int ADDR_WIDTH = ifc_pkg::IFC_ADDR_WIDTH
) ();

    logic                  buf_empty;
    logic                  buf_rd_en;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;

    modport master (
        input  buf_empty, buf_data, instr_ready,
        output buf_rd_en, buf_rd_addr, instr_valid, instr_data
    );

    modport slave (
        output buf_empty, buf_data, instr_ready,
        input  buf_rd_en, buf_rd_addr, instr_valid, instr_data
    );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Read-side sequencer: fetches a contiguous, wrapping run of words from the
// instruction buffer and hands them one at a time to the core over valid/ready.
module instr_fetch_ctrl
    import ifc_pkg::*;
#(
    parameter int DATA_WIDTH = IFC_DATA_WIDTH,
    parameter int ADDR_WIDTH = IFC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   instr_count,
    instr_fetch_ctrl_if.master    bus,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]            state_q,       state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,      rd_ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q,   remaining_d;
    logic [DATA_WIDTH-1:0] instr_data_q,  instr_data_d;
    logic                  instr_valid_q, instr_valid_d;

    // Next-state logic for the FSM, address/remaining counters and output word.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        remaining_d   = remaining_q;
        instr_data_d  = instr_data_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_ptr_d    = base_addr;
                    remaining_d = instr_count;
                    state_d     = (instr_count == '0) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An empty buffer stalls here with no read for as long as it lasts.
                if (!bus.buf_empty) begin
                    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
                    state_d     = ST_CAPTURE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_CAPTURE: begin
                instr_data_d  = bus.buf_data;
                instr_valid_d = 1'b1;
                state_d       = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_valid_q && bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = (remaining_q == '0) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            remaining_q   <= '0;
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            remaining_q   <= remaining_d;
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Read strobe is decoded from state so it can never fire outside FETCH or on empty.
    always_comb begin
        if ((state_q == ST_FETCH) && !bus.buf_empty) begin
            bus.buf_rd_en = 1'b1;
        end else begin
            bus.buf_rd_en = 1'b0;
        end
    end

    assign bus.buf_rd_addr = rd_ptr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_data  = instr_data_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a table of plain runs plus hand-written
// backpressure, empty-stall, restart-while-busy and reset-mid-run sequences.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  instr_count;
    logic        busy;
    logic        done;
    logic [31:0] mem [16];
    logic [31:0] rdata_q;
    int          n_checks = 0;
    int          n_fail   = 0;

    instr_fetch_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    instr_fetch_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .instr_count (instr_count),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Buffer model: registered read data, valid the cycle after buf_rd_en.
    always @(posedge clk) begin
        if (bus.buf_rd_en) rdata_q <= mem[bus.buf_rd_addr];
    end
    assign bus.buf_data = rdata_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction; cycle 0 is the edge that samples start.
    task automatic run(input logic [3:0] b, input logic [4:0] n,
                       input int rlo_from, input int rlo_len,
                       input int emp_from, input int emp_len, input int restart_at,
                       output int done_cyc, output int first_vcyc, output int first_rcyc,
                       output int n_hs, output int n_rd,
                       output logic [31:0] first_d, output logic [31:0] last_d);
        int          n_done;
        logic        pv, phs, fin;
        logic [31:0] pd;
        logic [3:0]  idx;
        done_cyc = -1; first_vcyc = 0; first_rcyc = 0; n_hs = 0; n_rd = 0;
        first_d = 32'h0; last_d = 32'h0; n_done = 0;
        pv = 1'b0; phs = 1'b0; pd = 32'h0; fin = 1'b0;
        base_addr = b; instr_count = n; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 400 && !fin; c++) begin
            start = (c == restart_at);
            if (c == restart_at) begin
                base_addr   = b + 4'd7;
                instr_count = 5'd3;
            end
            bus.buf_empty   = (c >= emp_from) && (c < emp_from + emp_len);
            bus.instr_ready = !((c >= rlo_from) && (c < rlo_from + rlo_len));
            #1;
            if (pv && !phs) begin
                chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
                chk("hold_data", bus.instr_data, pd);
            end
            if (bus.buf_rd_en) begin
                idx = b + n_rd[3:0];
                chk("rd_addr", {28'd0, bus.buf_rd_addr}, {28'd0, idx});
                chk("rd_en_while_empty", {31'd0, bus.buf_empty}, 32'd0);
                chk("rd_en_while_valid", {31'd0, bus.instr_valid}, 32'd0);
                if (n_rd == 0) first_rcyc = c;
                n_rd++;
            end
            if (done_cyc < 0) chk("busy", {31'd0, busy}, 32'd1);
            if (bus.instr_valid && first_vcyc == 0) first_vcyc = c;
            if (bus.instr_valid && bus.instr_ready) begin
                idx = b + n_hs[3:0];
                chk("hs_data", bus.instr_data, mem[idx]);
                if (n_hs == 0) first_d = bus.instr_data;
                last_d = bus.instr_data;
                n_hs++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end else if (done_cyc >= 0) begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_valid", {31'd0, bus.instr_valid}, 32'd0);
                fin = 1'b1;
            end
            pv  = bus.instr_valid;
            phs = bus.instr_valid && bus.instr_ready;
            pd  = bus.instr_data;
            if (!fin) tick();
        end
        chk("timeout", {31'd0, fin}, 32'd1);
        chk("done_pulses", n_done, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  cnt;
        int          exp_done;
        int          exp_first_v;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_reads;
    } vec_t;

    vec_t        vecs [6];
    int          dc, fv, fr, nh, nr;
    logic [31:0] fd, ld;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + i;
        vecs[0] = '{4'd0,  5'd4,  13, 3, 32'hA0, 32'hA3, 4};
        vecs[1] = '{4'd14, 5'd4,  13, 3, 32'hAE, 32'hA1, 4};
        vecs[2] = '{4'd5,  5'd1,  4,  3, 32'hA5, 32'hA5, 1};
        vecs[3] = '{4'd0,  5'd0,  1,  0, 32'h0,  32'h0,  0};
        vecs[4] = '{4'd3,  5'd16, 49, 3, 32'hA3, 32'hA2, 16};
        vecs[5] = '{4'd15, 5'd2,  7,  3, 32'hAF, 32'hA0, 2};

        rst_n = 1'b0; start = 1'b0; base_addr = 4'd0; instr_count = 5'd0;
        bus.buf_empty = 1'b0; bus.instr_ready = 1'b1;
        tick(); tick();
        chk("rst_rd_en", {31'd0, bus.buf_rd_en}, 32'd0);
        chk("rst_rd_addr", {28'd0, bus.buf_rd_addr}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_data", bus.instr_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].base, vecs[v].cnt, 0, 0, 0, 0, -1, dc, fv, fr, nh, nr, fd, ld);
            chk("vec_done_cycle", dc, vecs[v].exp_done);
            chk("vec_first_valid", fv, vecs[v].exp_first_v);
            chk("vec_first_data", fd, vecs[v].exp_first);
            chk("vec_last_data", ld, vecs[v].exp_last);
            chk("vec_reads", nr, vecs[v].exp_reads);
            chk("vec_handshakes", nh, {27'd0, vecs[v].cnt});
        end

        // Backpressure: ready low for cycles 3..7, run 5 cycles longer.
        run(4'd0, 5'd2, 3, 5, 0, 0, -1, dc, fv, fr, nh, nr, fd, ld);
        chk("bp_done_cycle", dc, 32'd12);
        chk("bp_first_valid", fv, 32'd3);
        chk("bp_handshakes", nh, 32'd2);
        chk("bp_last_data", ld, 32'hA1);

        // Empty stall for cycles 1..4: read issued in cycle 5.
        run(4'd4, 5'd1, 0, 0, 1, 4, -1, dc, fv, fr, nh, nr, fd, ld);
        chk("stall_first_read", fr, 32'd5);
        chk("stall_first_valid", fv, 32'd7);
        chk("stall_done_cycle", dc, 32'd8);
        chk("stall_data", fd, 32'hA4);

        // Second start in CAPTURE must be ignored.
        run(4'd2, 5'd2, 0, 0, 0, 0, 2, dc, fv, fr, nh, nr, fd, ld);
        chk("restart_done_cycle", dc, 32'd7);
        chk("restart_reads", nr, 32'd2);
        chk("restart_first", fd, 32'hA2);
        chk("restart_last", ld, 32'hA3);

        // Reset while PRESENT: everything clears, no done pulse follows.
        base_addr = 4'd0; instr_count = 5'd3; start = 1'b1; bus.instr_ready = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("mid_valid_before_rst", {31'd0, bus.instr_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_rst_data", bus.instr_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, bus.buf_rd_en}, 32'd0);
        chk("mid_rst_rd_addr", {28'd0, bus.buf_rd_addr}, 32'd0);
        rst_n = 1'b1; bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_done", {31'd0, done}, 32'd0);
        end
        run(4'd10, 5'd1, 0, 0, 0, 0, -1, dc, fv, fr, nh, nr, fd, ld);
        chk("post_rst_data", fd, 32'hAA);
        chk("post_rst_done_cycle", dc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
